// File: rtl/am29761_rdctl.sv
// am29761_rdctl: read controller for am29761-style 256xN PROMs with dual
// active-low chip selects. Drives address and selects for WAIT cycles,
// captures q, and presents it with a one-cycle valid strobe.
// Optional feature macro: AM29761_RDCTL_BURST_EN (multi-word bursts via blen).
module am29761_rdctl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SIZE  = 8,
  parameter int unsigned WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [SIZE-1:0]  addr,
`ifdef AM29761_RDCTL_BURST_EN
  input  logic [SIZE-1:0]  blen,
`endif
  output logic             busy,
  output logic             valid,
  output logic             last,
  output logic [WIDTH-1:0] dout,
  output logic [SIZE-1:0]  a,
  output logic             cs1_,
  output logic             cs2_,
  input  logic [WIDTH-1:0] q
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SIZE-1:0]  a_q;
  logic             cs_n_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
`ifdef AM29761_RDCTL_BURST_EN
  logic [SIZE-1:0]  rem_q;
`endif

  // Both selects always move together, so one register drives both pins.
  assign a     = a_q;
  assign cs1_  = cs_n_q;
  assign cs2_  = cs_n_q;
  assign dout  = dout_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = busy_q;

  // Read FSM: accept request in IDLE, count access cycles, capture q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      cs_n_q  <= 1'b1;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef AM29761_RDCTL_BURST_EN
      rem_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            a_q     <= addr;
            cs_n_q  <= 1'b0;
            cnt_q   <= CNT_W'(WAIT - 1);
            busy_q  <= 1'b1;
`ifdef AM29761_RDCTL_BURST_EN
            rem_q   <= blen;
`endif
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // q is only sampled here, while both selects are asserted.
            dout_q  <= q;
            valid_q <= 1'b1;
`ifdef AM29761_RDCTL_BURST_EN
            if (rem_q == '0) begin
              last_q  <= 1'b1;
              cs_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              // Selects stay low; step to the next word, wrapping at the top.
              rem_q <= rem_q - SIZE'(1);
              a_q   <= a_q + SIZE'(1);
              cnt_q <= CNT_W'(WAIT - 1);
            end
`else
            last_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
